// File: rtl/collision_pair_scheduler_pkg.sv
// Fixed-point defaults and FSM state encoding shared by the collision pair scheduler
// and its contact test.
package collision_pair_scheduler_pkg;

    localparam int FP_WIDTH      = 32;
    localparam int FP_FRAC_WIDTH = 30;

    localparam logic [FP_WIDTH-1:0] ONE  = FP_WIDTH'(1) << FP_FRAC_WIDTH;
    localparam logic [FP_WIDTH-1:0] ZERO = '0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_RD_J,
        ST_CHECK,
        ST_ENGINE,
        ST_WB_I,
        ST_WB_J,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/collision_pair_scheduler_pair_contact_test.sv
// Combinational contact-and-approach test for one ball pair (i, j).
// All intermediate products are kept at full width so no comparison sees a truncated value.
module pair_contact_test
    import collision_pair_scheduler_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH,
    parameter int FRAC_WIDTH = FP_FRAC_WIDTH
) (
    input  logic [WIDTH-1:0] xi_i,
    input  logic [WIDTH-1:0] yi_i,
    input  logic [WIDTH-1:0] vxi_i,
    input  logic [WIDTH-1:0] vyi_i,
    input  logic [WIDTH-1:0] xj_i,
    input  logic [WIDTH-1:0] yj_i,
    input  logic [WIDTH-1:0] vxj_i,
    input  logic [WIDTH-1:0] vyj_i,
    input  logic [WIDTH-1:0] diam2_i,
    output logic             hit_o
);

    // One guard bit on the differences, one on the sums, so nothing can wrap.
    localparam int DW = WIDTH + 1;
    localparam int PW = 2 * DW;
    localparam int SW = PW + 1;

    logic signed [DW-1:0] dx, dy, dvx, dvy;
    logic signed [PW-1:0] dxx, dyy, dxvx, dyvy;
    logic signed [SW-1:0] dist2, dist2_sh, dot, diam2_ext;

    always_comb begin
        dx        = {xj_i[WIDTH-1], xj_i}   - {xi_i[WIDTH-1], xi_i};
        dy        = {yj_i[WIDTH-1], yj_i}   - {yi_i[WIDTH-1], yi_i};
        dvx       = {vxj_i[WIDTH-1], vxj_i} - {vxi_i[WIDTH-1], vxi_i};
        dvy       = {vyj_i[WIDTH-1], vyj_i} - {vyi_i[WIDTH-1], vyi_i};
        dxx       = PW'(dx) * PW'(dx);
        dyy       = PW'(dy) * PW'(dy);
        dxvx      = PW'(dx) * PW'(dvx);
        dyvy      = PW'(dy) * PW'(dvy);
        dist2     = SW'(dxx) + SW'(dyy);
        dist2_sh  = dist2 >>> FRAC_WIDTH;
        dot       = SW'(dxvx) + SW'(dyvy);
        diam2_ext = SW'({1'b0, diam2_i});
        // Coincident centres have no contact normal, so they never count as a hit.
        hit_o     = ((dx != '0) || (dy != '0)) && (dist2_sh < diam2_ext) && (dot < 0);
    end

endmodule

// File: rtl/collision_pair_scheduler.sv
// Sweeps every ball pair (i<j), hands colliding pairs to the external velocity engine and
// writes both new velocities back before moving on, so later pairs see updated state.
module collision_pair_scheduler
    import collision_pair_scheduler_pkg::*;
#(
    parameter int               WIDTH      = FP_WIDTH,
    parameter int               FRAC_WIDTH = FP_FRAC_WIDTH,
    parameter int               N_BALLS    = 16,
    parameter int               ADDR_W     = 4,
    parameter logic [WIDTH-1:0] DIAM2      = WIDTH'(32'h00A3_D70A),
    parameter int               TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [4*WIDTH-1:0]   rd_data_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [2*WIDTH-1:0]   wr_data_o,
    output logic [WIDTH-1:0]     eng_x0_o,
    output logic [WIDTH-1:0]     eng_y0_o,
    output logic [WIDTH-1:0]     eng_v0_x_o,
    output logic [WIDTH-1:0]     eng_v0_y_o,
    output logic [WIDTH-1:0]     eng_x1_o,
    output logic [WIDTH-1:0]     eng_y1_o,
    output logic [WIDTH-1:0]     eng_v1_x_o,
    output logic [WIDTH-1:0]     eng_v1_y_o,
    input  logic                 eng_done_i,
    input  logic [WIDTH-1:0]     eng_v0_x_i,
    input  logic [WIDTH-1:0]     eng_v0_y_i,
    input  logic [WIDTH-1:0]     eng_v1_x_i,
    input  logic [WIDTH-1:0]     eng_v1_y_i,
    output logic                 busy_o,
    output logic                 sweep_done_o,
    output logic [15:0]          hit_count_o,
    output logic                 timeout_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     LAST_T = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'((N_BALLS > 0) ? N_BALLS - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'((N_BALLS > 1) ? N_BALLS - 2 : 0);

    // Element 3 is the most significant word: {x, y, vx, vy} for balls, {v0x, v0y, v1x, v1y} for results.
    typedef logic [3:0][WIDTH-1:0] quad_t;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d;
    logic [TW-1:0]       timer_q, timer_d;
    quad_t               ball_i_q, ball_i_d, ball_j_q, ball_j_d, res_q, res_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic                terr_q, terr_d;
    quad_t               rd_ball;
    logic                hit;

    assign rd_ball = rd_data_i;

    pair_contact_test #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_contact (
        .xi_i    (ball_i_q[3]),
        .yi_i    (ball_i_q[2]),
        .vxi_i   (ball_i_q[1]),
        .vyi_i   (ball_i_q[0]),
        .xj_i    (rd_ball[3]),
        .yj_i    (rd_ball[2]),
        .vxj_i   (rd_ball[1]),
        .vyj_i   (rd_ball[0]),
        .diam2_i (DIAM2),
        .hit_o   (hit)
    );

    // NOTE: synchronous reset sampled on the clock edge; all state uses non-blocking
    // assignments so every register sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= ADDR_W'(1);
            timer_q   <= '0;
            ball_i_q  <= '0;
            ball_j_q  <= '0;
            res_q     <= '0;
            hit_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            timer_q   <= timer_d;
            ball_i_q  <= ball_i_d;
            ball_j_q  <= ball_j_d;
            res_q     <= res_d;
            hit_cnt_q <= hit_cnt_d;
            terr_q    <= terr_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        timer_d   = timer_q;
        ball_i_d  = ball_i_q;
        ball_j_d  = ball_j_q;
        res_d     = res_q;
        hit_cnt_d = hit_cnt_q;
        terr_d    = terr_q;
        rd_addr_o = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    hit_cnt_d = '0;
                    i_d       = '0;
                    j_d       = ADDR_W'(1);
                    state_d   = (N_BALLS < 2) ? ST_DONE : ST_RD_I;
                end
            end
            ST_RD_I: begin
                rd_addr_o = i_q;
                state_d   = ST_RD_J;
            end
            ST_RD_J: begin
                ball_i_d  = rd_ball;
                rd_addr_o = j_q;
                state_d   = ST_CHECK;
            end
            ST_CHECK: begin
                ball_j_d = rd_ball;
                timer_d  = '0;
                state_d  = hit ? ST_ENGINE : ST_NEXT;
            end
            ST_ENGINE: begin
                // eng_done may still be high from the previous pair on the first cycle.
                if ((timer_q != '0) && eng_done_i) begin
                    res_d   = {eng_v0_x_i, eng_v0_y_i, eng_v1_x_i, eng_v1_y_i};
                    state_d = ST_WB_I;
                end else if (timer_q == LAST_T) begin
                    terr_d  = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WB_I: begin
                wr_en_o   = 1'b1;
                wr_addr_o = i_q;
                wr_data_o = {res_q[3], res_q[2]};
                state_d   = ST_WB_J;
            end
            ST_WB_J: begin
                wr_en_o   = 1'b1;
                wr_addr_o = j_q;
                wr_data_o = {res_q[1], res_q[0]};
                hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                state_d   = ST_NEXT;
            end
            ST_NEXT: begin
                if (j_q == LAST_J) begin
                    if (i_q == LAST_I) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + ADDR_W'(1);
                        j_d     = i_q + ADDR_W'(2);
                        state_d = ST_RD_I;
                    end
                end else begin
                    j_d     = j_q + ADDR_W'(1);
                    state_d = ST_RD_I;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign eng_x0_o      = ball_i_q[3];
    assign eng_y0_o      = ball_i_q[2];
    assign eng_v0_x_o    = ball_i_q[1];
    assign eng_v0_y_o    = ball_i_q[0];
    assign eng_x1_o      = ball_j_q[3];
    assign eng_y1_o      = ball_j_q[2];
    assign eng_v1_x_o    = ball_j_q[1];
    assign eng_v1_y_o    = ball_j_q[0];
    assign busy_o        = (state_q != ST_IDLE);
    assign sweep_done_o  = (state_q == ST_DONE);
    assign hit_count_o   = hit_cnt_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Bench for collision_pair_scheduler: synchronous ball RAM, a behavioural elastic-collision
// engine, directed scenarios and randomized sweeps checked against a pairwise sweep model.
module tb_collision_pair_scheduler;

    localparam int  TB_N    = 3;
    localparam int  AW      = 2;
    localparam int  TMO     = 64;
    localparam int  LAT     = 3;
    localparam real ONE_R   = 1073741824.0;
    localparam longint DIAM = 64'h00A3_D70A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [127:0]  rd_data = '0;
    logic          wr_en;
    logic [63:0]   wr_data;
    logic [31:0]   e_x0, e_y0, e_v0x, e_v0y, e_x1, e_y1, e_v1x, e_v1y;
    logic          eng_done = 1'b0;
    logic [31:0]   r_v0x = '0, r_v0y = '0, r_v1x = '0, r_v1y = '0;
    logic          busy, sweep_done, timeout_err;
    logic [15:0]   hit_count;

    logic [31:0] m_x[TB_N], m_y[TB_N], m_vx[TB_N], m_vy[TB_N];
    logic [31:0] x_vx[TB_N], x_vy[TB_N];
    bit          eng_stall = 1'b0;

    int errors = 0, checks = 0;
    int wr_cnt, done_cnt, busy_cnt;
    logic [AW-1:0] wlog_a[$];
    logic [63:0]   wlog_d[$];

    always #5 clk = ~clk;

    collision_pair_scheduler #(
        .N_BALLS (TB_N), .ADDR_W (AW), .TIMEOUT (TMO)
    ) dut (
        .clk (clk), .rst (rst), .start_i (start),
        .rd_addr_o (rd_addr), .rd_data_i (rd_data),
        .wr_en_o (wr_en), .wr_addr_o (wr_addr), .wr_data_o (wr_data),
        .eng_x0_o (e_x0), .eng_y0_o (e_y0), .eng_v0_x_o (e_v0x), .eng_v0_y_o (e_v0y),
        .eng_x1_o (e_x1), .eng_y1_o (e_y1), .eng_v1_x_o (e_v1x), .eng_v1_y_o (e_v1y),
        .eng_done_i (eng_done),
        .eng_v0_x_i (r_v0x), .eng_v0_y_i (r_v0y), .eng_v1_x_i (r_v1x), .eng_v1_y_i (r_v1y),
        .busy_o (busy), .sweep_done_o (sweep_done),
        .hit_count_o (hit_count), .timeout_err_o (timeout_err)
    );

    function automatic real q2r(input logic [31:0] v);
        return $itor($signed(v)) / ONE_R;
    endfunction

    function automatic logic [31:0] r2q(input real r);
        longint t;
        t = longint'(r * ONE_R);
        return t[31:0];
    endfunction

    // Equal-mass elastic collision along the line of centres.
    task automatic engine_calc(input logic [31:0] x0, y0, v0x, v0y, x1, y1, v1x, v1y,
                               output logic [31:0] n0x, n0y, n1x, n1y);
        real dx, dy, d2, k;
        dx = q2r(x0) - q2r(x1);
        dy = q2r(y0) - q2r(y1);
        d2 = dx * dx + dy * dy;
        if (d2 == 0.0) begin
            n0x = v0x; n0y = v0y; n1x = v1x; n1y = v1y;
        end else begin
            k   = ((q2r(v0x) - q2r(v1x)) * dx + (q2r(v0y) - q2r(v1y)) * dy) / d2;
            n0x = r2q(q2r(v0x) - k * dx);
            n0y = r2q(q2r(v0y) - k * dy);
            n1x = r2q(q2r(v1x) + k * dx);
            n1y = r2q(q2r(v1y) + k * dy);
        end
    endtask

    // Synchronous RAM: read data one cycle after the address, velocity-only writes.
    always @(posedge clk) begin
        rd_data <= {m_x[rd_addr], m_y[rd_addr], m_vx[rd_addr], m_vy[rd_addr]};
        if (wr_en) begin
            m_vx[wr_addr] = wr_data[63:32];
            m_vy[wr_addr] = wr_data[31:0];
        end
    end

    // Engine: results follow the operands; done rises LAT cycles after operands settle.
    logic [255:0] op_snap = '0;
    int           eng_cnt = 0;
    always @(negedge clk) begin
        if ({e_x0, e_y0, e_v0x, e_v0y, e_x1, e_y1, e_v1x, e_v1y} !== op_snap) begin
            op_snap  = {e_x0, e_y0, e_v0x, e_v0y, e_x1, e_y1, e_v1x, e_v1y};
            eng_cnt  = 0;
            eng_done = 1'b0;
            engine_calc(e_x0, e_y0, e_v0x, e_v0y, e_x1, e_y1, e_v1x, e_v1y,
                        r_v0x, r_v0y, r_v1x, r_v1y);
        end else begin
            if (eng_cnt < LAT) eng_cnt++;
            eng_done = !eng_stall && (eng_cnt >= LAT);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [31:0] obs, input real exp_r);
        longint d;
        d = longint'($signed(obs)) - longint'($signed(r2q(exp_r)));
        checks++;
        assert (d >= -4 && d <= 4) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (+/-4)", tag, $signed(obs), $signed(r2q(exp_r)));
        end
    endtask

    task automatic load(input int idx, input real x, y, vx, vy);
        m_x[idx] = r2q(x); m_y[idx] = r2q(y); m_vx[idx] = r2q(vx); m_vy[idx] = r2q(vy);
    endtask

    task automatic tick();
        @(negedge clk);
        if (wr_en) begin
            wr_cnt++;
            wlog_a.push_back(wr_addr);
            wlog_d.push_back(wr_data);
        end
        if (sweep_done) done_cnt++;
        if (busy && !sweep_done) busy_cnt++;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
        wlog_a.delete(); wlog_d.delete();
    endtask

    // Starts one sweep and waits for its end; hold keeps start high into the DONE cycle.
    task automatic run_sweep(input bit hold);
        int n;
        clear_counts();
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            tick();
            n++;
        end
        check("sweep_completes_in_bound", done_cnt, 1);
        tick();
        if (hold) check("start_in_done_ignored_busy", busy, 0);
        start = 1'b0;
        tick();
        check("sweep_done_single_pulse", done_cnt, 1);
    endtask

    // Sweep model: pairs in (i,j) order, updated velocities visible to later pairs.
    task automatic model_sweep(output int hits);
        longint dx, dy, dvx, dvy, dist2, dot;
        logic [31:0] n0x, n0y, n1x, n1y;
        hits = 0;
        for (int b = 0; b < TB_N; b++) begin
            x_vx[b] = m_vx[b]; x_vy[b] = m_vy[b];
        end
        for (int i = 0; i < TB_N - 1; i++) begin
            for (int j = i + 1; j < TB_N; j++) begin
                dx    = longint'($signed(m_x[j])) - longint'($signed(m_x[i]));
                dy    = longint'($signed(m_y[j])) - longint'($signed(m_y[i]));
                dvx   = longint'($signed(x_vx[j])) - longint'($signed(x_vx[i]));
                dvy   = longint'($signed(x_vy[j])) - longint'($signed(x_vy[i]));
                dist2 = dx * dx + dy * dy;
                dot   = dx * dvx + dy * dvy;
                if ((dx != 0 || dy != 0) && ((dist2 >>> 30) < DIAM) && dot < 0) begin
                    engine_calc(m_x[i], m_y[i], x_vx[i], x_vy[i], m_x[j], m_y[j], x_vx[j], x_vy[j],
                                n0x, n0y, n1x, n1y);
                    x_vx[i] = n0x; x_vy[i] = n0y; x_vx[j] = n1x; x_vy[j] = n1y;
                    hits++;
                end
            end
        end
    endtask

    initial begin
        int hits;
        logic [31:0] px[TB_N], py[TB_N];
        for (int b = 0; b < TB_N; b++) load(b, 0.0, 0.0, 0.0, 0.0);
        clear_counts();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_eng_x0", e_x0, 0);
        rst = 1'b0;

        // Head-on: b0 moving into b1 at rest, b2 parked far away.
        load(0, 0.0, 0.0, 0.5, 0.0); load(1, 0.05, 0.0, 0.0, 0.0); load(2, 1.5, 1.5, 0.0, 0.0);
        run_sweep(1'b0);
        check("headon_writes", wr_cnt, 2);
        check("headon_hit_count", hit_count, 1);
        if (wlog_a.size() == 2) begin
            check("headon_wr_addr0", wlog_a[0], 0);
            check("headon_wr_addr1", wlog_a[1], 1);
        end
        check_tol("headon_v0x", m_vx[0], 0.0);
        check_tol("headon_v0y", m_vy[0], 0.0);
        check_tol("headon_v1x", m_vx[1], 0.5);
        check_tol("headon_v1y", m_vy[1], 0.0);
        check("headon_x1_untouched", m_x[1], r2q(0.05));
        check("headon_timeout_err", timeout_err, 0);

        // Separating pair: in range but moving apart.
        load(0, 0.0, 0.0, -0.5, 0.0); load(1, 0.05, 0.0, 0.0, 0.0);
        run_sweep(1'b0);
        check("separating_writes", wr_cnt, 0);
        check("separating_hit_count", hit_count, 0);
        check("separating_cycles", busy_cnt, 12);
        check("separating_v0x", m_vx[0], r2q(-0.5));

        // Out of range, start held high across the whole sweep.
        load(0, 0.0, 0.0, 0.5, 0.0); load(1, 0.5, 0.0, -0.5, 0.0); load(2, 1.0, 0.0, 0.0, 0.5);
        run_sweep(1'b1);
        check("far_writes", wr_cnt, 0);
        check("far_cycles_3_pairs", busy_cnt, 12);
        check("far_hit_count", hit_count, 0);

        // Engine never answers: one timeout, no write, sweep still finishes.
        eng_stall = 1'b1;
        load(0, 0.0, 0.0, 0.5, 0.0); load(1, 0.05, 0.0, 0.0, 0.0); load(2, 1.5, 1.5, 0.0, 0.0);
        run_sweep(1'b0);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_writes", wr_cnt, 0);
        check("timeout_hit_count", hit_count, 0);
        check("timeout_cycles", busy_cnt, 12 + TMO);
        check("timeout_v0x_kept", m_vx[0], r2q(0.5));

        // Reset while waiting on the engine.
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_timeout_err_cleared", timeout_err, 0);
        clear_counts();
        repeat (80) tick();
        check("midrst_no_writes", wr_cnt, 0);
        check("midrst_no_sweep_done", done_cnt, 0);
        eng_stall = 1'b0;
        run_sweep(1'b0);
        check("after_rst_hit_count", hit_count, 1);
        check_tol("after_rst_v1x", m_vx[1], 0.5);

        // Chain: momentum passes 0 -> 1 -> 2 within one sweep.
        load(0, 0.0, 0.0, 0.5, 0.0); load(1, 0.05, 0.0, 0.0, 0.0); load(2, 0.1, 0.0, 0.0, 0.0);
        run_sweep(1'b0);
        check("chain_hit_count", hit_count, 2);
        check("chain_writes", wr_cnt, 4);
        if (wlog_a.size() == 4) begin
            check("chain_wr1_addr", wlog_a[1], 1);
            check_tol("chain_wr1_vx", wlog_d[1][63:32], 0.5);
            check("chain_wr3_addr", wlog_a[3], 2);
            check_tol("chain_wr3_vx", wlog_d[3][63:32], 0.5);
        end
        check_tol("chain_b0_vx", m_vx[0], 0.0);
        check_tol("chain_b1_vx", m_vx[1], 0.0);
        check_tol("chain_b2_vx", m_vx[2], 0.5);

        // Randomized clusters against the sweep model.
        for (int r = 0; r < 30; r++) begin
            for (int b = 0; b < TB_N; b++) begin
                m_x[b]  = 32'($urandom_range(0, 128849018));
                m_y[b]  = 32'($urandom_range(0, 128849018));
                m_vx[b] = 32'($urandom_range(0, 536870912)) - 32'd268435456;
                m_vy[b] = 32'($urandom_range(0, 536870912)) - 32'd268435456;
                px[b] = m_x[b]; py[b] = m_y[b];
            end
            model_sweep(hits);
            run_sweep(1'b0);
            check($sformatf("rand%0d_hit_count", r), hit_count, hits);
            check($sformatf("rand%0d_writes", r), wr_cnt, 2 * hits);
            for (int b = 0; b < TB_N; b++) begin
                check($sformatf("rand%0d_b%0d_vx", r, b), m_vx[b], x_vx[b]);
                check($sformatf("rand%0d_b%0d_vy", r, b), m_vy[b], x_vy[b]);
                check($sformatf("rand%0d_b%0d_pos", r, b), {m_x[b], m_y[b]}, {px[b], py[b]});
            end
        end
        check("final_timeout_err", timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
